// File: rtl/audio_stream_sched.sv
// audio_stream_sched: prefetches SD sectors into a byte FIFO and paces them out as
// 8-bit unsigned samples, looping over a fixed sector range with error lockout.
module audio_stream_sched #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SAMPLE_RATE  = 44_100,
    parameter int START_SECTOR = 0,
    parameter int NUM_SECTORS  = 1024,
    parameter int FIFO_DEPTH   = 2048
) (
    input  logic        CLK_100MHZ,
    input  logic        RESET_N,
    input  logic        play,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    input  logic        sd_byte_valid,
    input  logic [7:0]  sd_byte,
    input  logic        sd_err,
    output logic [7:0]  sample_out,
    output logic        sample_tick,
    output logic        underrun,
    output logic        err,
    output logic [2:0]  status
);

    localparam int DIV = CLK_HZ / SAMPLE_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    localparam logic [CW-1:0] DIV_LAST    = CW'(DIV - 1);
    localparam logic [31:0]   FIRST_SECT  = 32'(START_SECTOR);
    localparam logic [31:0]   LAST_SECT   = 32'(START_SECTOR + NUM_SECTORS - 1);
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] SPACE_LEVEL = LW'(FIFO_DEPTH - 512);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_SPACE = 3'd1,
        S_REQ   = 3'd2,
        S_RECV  = 3'd3,
        S_NEXT  = 3'd4,
        S_ERR   = 3'd7
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [8:0]      byte_cnt;
    logic [31:0]     cur;
    logic [CW-1:0]   div_cnt;
    logic            space_ok, streaming;
    logic            fifo_empty, fifo_full, rx, push, pop, overflow, tick, sector_done;

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == FULL_LEVEL);
    assign tick        = play && (div_cnt == DIV_LAST);
    assign pop         = tick && !fifo_empty;
    assign rx          = (state == S_RECV) && sd_byte_valid && !sd_err;
    assign push        = rx && !fifo_full;
    assign overflow    = rx && fifo_full;
    assign sector_done = push && (byte_cnt == 9'd511);
    assign sd_addr     = cur;
    assign status      = state;

    always_comb begin
        state_nxt = state;
        sd_rd     = 1'b0;
        case (state)
            S_INIT:  if (sd_ready) state_nxt = S_SPACE;
            S_SPACE: if (space_ok && sd_ready) state_nxt = S_REQ;
            S_REQ: begin
                sd_rd     = 1'b1;
                state_nxt = S_RECV;
            end
            S_RECV:  if (sector_done) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = S_SPACE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_INIT;
        endcase
        if (sd_err || overflow) state_nxt = S_ERR;
    end

    // space_ok is a registered qualifier, giving the request a two-cycle lead-in
    always_ff @(posedge CLK_100MHZ) begin
        if (!RESET_N) begin
            state    <= S_INIT;
            space_ok <= 1'b0;
        end else begin
            state    <= state_nxt;
            space_ok <= (state == S_SPACE) && sd_ready && (level <= SPACE_LEVEL);
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (!RESET_N) begin
            cur       <= FIRST_SECT;
            byte_cnt  <= '0;
            streaming <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state == S_REQ) byte_cnt <= '0;
            else if (push)      byte_cnt <= byte_cnt + 9'd1;
            if (sector_done) streaming <= 1'b1;
            if (state == S_NEXT) cur <= (cur == LAST_SECT) ? FIRST_SECT : cur + 32'd1;
            if (state_nxt == S_ERR) err <= 1'b1;
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (push) mem[wr_ptr] <= sd_byte;
    end

    // An empty tick only counts as an underrun once real audio has started flowing
    always_ff @(posedge CLK_100MHZ) begin
        if (!RESET_N) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
            sample_out  <= 8'h80;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= tick;
            if (play) div_cnt <= tick ? '0 : div_cnt + CW'(1);
            if (tick) begin
                if (fifo_empty) begin
                    sample_out <= 8'h80;
                    if (streaming) underrun <= 1'b1;
                end else begin
                    sample_out <= mem[rd_ptr];
                end
            end
        end
    end

endmodule
